// File: rtl/delay_seq_ctrl.sv
// Sequencing controller for an external long/short delay line: fills it, qualifies the
// returned strobes once stale content has drained, and flushes it with zero samples.
module delay_seq_ctrl #(
  parameter int unsigned PAR_DATA_WIDTH       = 32,
  parameter int unsigned PAR_LONG_STEP_DELAY  = 512,
  parameter int unsigned PAR_SHORT_STEP_DELAY = 64,
  localparam int unsigned CW = $clog2(PAR_LONG_STEP_DELAY + PAR_SHORT_STEP_DELAY + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_enable,
  input  logic                      i_flush,
  input  logic                      s_axis_tvalid,
  input  logic [PAR_DATA_WIDTH-1:0] s_axis_tdata,
  output logic                      s_axis_tready,
  output logic                      m_axis_tvalid,
  output logic [PAR_DATA_WIDTH-1:0] m_axis_tdata,
  input  logic                      i_dly_tvalid,
  output logic                      o_out_tvalid,
  output logic [1:0]                o_state,
  output logic [CW-1:0]             o_fill_cnt
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StRun   = 2'd2,
    StFlush = 2'd3
  } state_e;

  localparam logic [CW-1:0] One        = CW'(1);
  localparam logic [CW-1:0] LenLong    = CW'(PAR_LONG_STEP_DELAY);
  localparam logic [CW-1:0] LenLongM1  = CW'(PAR_LONG_STEP_DELAY - 1);
  localparam logic [CW-1:0] FlushLast  =
      CW'(PAR_LONG_STEP_DELAY + PAR_SHORT_STEP_DELAY - 1);

  state_e        state_q;
  logic [CW-1:0] fill_cnt_q;
  logic [CW-1:0] ret_cnt_q;
  logic [CW-1:0] flush_cnt_q;
  logic          accept;

  assign accept = s_axis_tvalid & ((state_q == StFill) | (state_q == StRun));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      fill_cnt_q  <= '0;
      ret_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (i_enable) begin
            state_q    <= StFill;
            fill_cnt_q <= '0;
            ret_cnt_q  <= '0;
          end
        end
        StFill, StRun: begin
          if (!i_enable) begin
            state_q     <= StIdle;
            fill_cnt_q  <= '0;
            ret_cnt_q   <= '0;
            flush_cnt_q <= '0;
          end else if (i_flush) begin
            state_q     <= StFlush;
            flush_cnt_q <= '0;
          end else begin
            // Returned strobes are counted until the line holds only fresh samples.
            if (i_dly_tvalid && (ret_cnt_q != LenLong)) begin
              ret_cnt_q <= ret_cnt_q + One;
            end
            if ((state_q == StFill) && accept) begin
              fill_cnt_q <= fill_cnt_q + One;
              if (fill_cnt_q == LenLongM1) begin
                state_q <= StRun;
              end
            end
          end
        end
        StFlush: begin
          if (flush_cnt_q == FlushLast) begin
            state_q     <= StIdle;
            flush_cnt_q <= '0;
          end else begin
            flush_cnt_q <= flush_cnt_q + One;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs are forced to their idle values while reset is asserted.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    if (!i_rst) begin
      case (state_q)
        StFill, StRun: begin
          s_axis_tready = 1'b1;
          m_axis_tvalid = s_axis_tvalid;
          m_axis_tdata  = s_axis_tdata;
        end
        StFlush: m_axis_tvalid = (flush_cnt_q < LenLong);
        default: ;
      endcase
    end
  end

  assign o_out_tvalid = ~i_rst & i_dly_tvalid & (state_q == StRun) & (ret_cnt_q == LenLong);
  assign o_state      = state_q;
  assign o_fill_cnt   = i_rst ? '0 : fill_cnt_q;

endmodule

// File: doc/delay_seq_ctrl.md
DELAY_SEQ_CTRL -- requirements
Module: delay_seq_ctrl

Interface
- REQ-001: Parameter PAR_DATA_WIDTH, default 32, sample width in bits.
- REQ-002: Parameter PAR_LONG_STEP_DELAY (L), default 512, per-sample depth of the controlled delay line; L >= 2.
- REQ-003: Parameter PAR_SHORT_STEP_DELAY (S), default 64, per-clock depth of the controlled delay line; S >= 2.
- REQ-004: Counter width CW = $clog2(L+S+1).
- REQ-005: i_clk  in  1  sole clock; all logic on rising edge.
- REQ-006: i_rst  in  1  reset, synchronous, active-high.
- REQ-007: i_enable  in  1  run request; level-sensitive.
- REQ-008: i_flush  in  1  flush request; single-cycle pulse or level.
- REQ-009: s_axis_tvalid  in  1  upstream sample valid.
- REQ-010: s_axis_tdata  in  PAR_DATA_WIDTH  upstream sample.
- REQ-011: s_axis_tready  out  1  upstream ready.
- REQ-012: m_axis_tvalid  out  1  sample strobe to the delay line input.
- REQ-013: m_axis_tdata  out  PAR_DATA_WIDTH  sample to the delay line input.
- REQ-014: i_dly_tvalid  in  1  valid returned from the delay line output.
- REQ-015: o_out_tvalid  out  1  qualified delay-line output valid; data is meaningful.
- REQ-016: o_state  out  2  IDLE=0, FILL=1, RUN=2, FLUSH=3.
- REQ-017: o_fill_cnt  out  CW  samples written since FILL entry, saturating at L.

Function
- REQ-018: FSM state is registered; o_state presents it directly.
- REQ-019: s_axis_tready = 1 in FILL and RUN; 0 in IDLE and FLUSH.
- REQ-020: In FILL/RUN: m_axis_tvalid = s_axis_tvalid & s_axis_tready, m_axis_tdata = s_axis_tdata, combinational, zero latency.
- REQ-021: In IDLE: m_axis_tvalid = 0 and m_axis_tdata = 0.
- REQ-022: IDLE -> FILL when i_enable = 1; fill_cnt and ret_cnt clear on this transition.
- REQ-023: FILL: fill_cnt += 1 per accepted sample (m_axis_tvalid = 1).
- REQ-024: FILL -> RUN on the cycle the L-th sample is accepted; o_fill_cnt = L from the next cycle and holds at L in RUN.
- REQ-025: ret_cnt increments on each i_dly_tvalid = 1 cycle while in FILL or RUN, saturating at L.
- REQ-026: o_out_tvalid = i_dly_tvalid & (state == RUN) & (ret_cnt == L), combinational on the registered ret_cnt.
- REQ-027: Consequence of REQ-025/026: the first L returned strobes are stale and are never qualified.
- REQ-028: FILL or RUN -> FLUSH when i_flush = 1 and i_enable = 1; i_flush is ignored in IDLE and FLUSH.
- REQ-029: FLUSH phase 1: L consecutive cycles, m_axis_tvalid = 1, m_axis_tdata = 0.
- REQ-030: FLUSH phase 2: S cycles, m_axis_tvalid = 0, to drain the short stage.
- REQ-031: FLUSH uses a cycle counter 0..L+S-1; after L+S cycles, FLUSH -> IDLE.
- REQ-032: i_enable = 0 in FILL or RUN -> IDLE next cycle; counters clear.
- REQ-033: FLUSH ignores i_enable and i_flush until it completes.
- REQ-034: Priority: i_rst > completion of FLUSH > i_enable = 0 > i_flush.
- REQ-035: A sample offered on a cycle whose transition leaves FILL/RUN is still accepted, because tready depends on the current state.

Reset
- REQ-036: On i_rst = 1 at a clock edge: state = IDLE; fill_cnt, ret_cnt and flush counter = 0.
- REQ-037: During and after reset: s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tdata = 0, o_out_tvalid = 0, o_fill_cnt = 0.
- REQ-038: Reset in any state, including mid-FLUSH, aborts immediately with no further strobes.

Verification (L=8, S=4, PAR_DATA_WIDTH=8)
- REQ-039: Fill: enable, s_axis_tvalid = 1 continuously -> state 1 for 8 accepted samples, then state 2; o_fill_cnt = 8.
- REQ-040: Qualification: model the delay line in the bench -> o_out_tvalid first asserts with sample #1 on the 9th returned strobe; 0 for the first 8.
- REQ-041: Flush from RUN -> 8 cycles of tvalid = 1 with data 0x00, then 4 cycles of tvalid = 0, then state 0; tready = 0 throughout.
- REQ-042: Mid-FILL disable after 3 samples -> IDLE next cycle; re-enable -> o_fill_cnt restarts at 0; o_out_tvalid stays 0 until 8 new returned strobes.
- REQ-043: Simultaneous i_flush = 1 and i_enable = 0 in RUN -> IDLE, no zero strobes.
- REQ-044: i_rst pulsed on flush cycle 5 -> m_axis_tvalid = 0 from the next cycle; all outputs equal their reset values.
